// File: rtl/cmp_arbiter.sv
// rtl/cmp_arbiter.sv - round-robin scheduler for one shared 16-bit ripple magnitude comparator
//
// Purpose:
//   Grants NUM_REQ requesters round-robin access to a single external ripple
//   comparator. The granted operands are registered onto cmp_a/cmp_b and held
//   for SETTLE cycles, which treats the ripple chain as a multicycle path. The
//   comparator outputs are then sampled into res_* and the requester gets a
//   one-cycle done pulse.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   req[NUM_REQ]         per-requester request level
//   sgn[NUM_REQ]         per-requester signed-compare select
//   op_a, op_b           16 bits per requester; requester i at [16i+15:16i]
//   gnt[NUM_REQ]         one-hot grant, high from issue until the DONE cycle
//   done[NUM_REQ]        one-hot, one-cycle completion pulse
//   res_gt/res_lt/res_eq registered comparison result
//   busy                 high whenever the scheduler is not idle
//   cmp_a, cmp_b         registered comparator operands
//   cmp_*_in             constant cascade inputs (gt=0, lt=0, eq=1)
//   cmp_gt/cmp_lt/cmp_eq comparator outputs, sampled only on the capture edge

module cmp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SETTLE  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     sgn,
  input  logic [16*NUM_REQ-1:0]  op_a,
  input  logic [16*NUM_REQ-1:0]  op_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   res_gt,
  output logic                   res_lt,
  output logic                   res_eq,
  output logic                   busy,
  output logic [15:0]            cmp_a,
  output logic [15:0]            cmp_b,
  output logic                   cmp_gt_in,
  output logic                   cmp_lt_in,
  output logic                   cmp_eq_in,
  input  logic                   cmp_gt,
  input  logic                   cmp_lt,
  input  logic                   cmp_eq
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   srv_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic               res_gt_q;
  logic               res_lt_q;
  logic               res_eq_q;
  logic               busy_q;
  logic [15:0]        cmp_a_q;
  logic [15:0]        cmp_b_q;

  logic [NUM_REQ-1:0] cand;
  logic               arb_valid;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   ptr_d;
  logic [15:0]        cmp_a_d;
  logic [15:0]        cmp_b_d;
  logic               issue;

  // Cascade inputs seed the MSB-first chain as "equal so far".
  assign cmp_gt_in = 1'b0;
  assign cmp_lt_in = 1'b0;
  assign cmp_eq_in = 1'b1;

  // Round-robin search starting at the pointer. In DONE the requester just
  // served is masked, because it may legally keep req high for this cycle.
  always_comb begin : arb_comb
    int pos;
    cand      = req;
    arb_valid = 1'b0;
    arb_idx   = '0;
    pos       = 0;
    if (state_q == ST_DONE) begin
      cand = req & ~(NUM_REQ'(1) << srv_q);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!arb_valid && cand[IDX_W'(pos)]) begin
        arb_valid = 1'b1;
        arb_idx   = IDX_W'(pos);
      end
    end
  end

  assign ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
  assign issue = arb_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Operand mux. Flipping bit 15 maps two's complement onto offset binary,
  // so the unsigned comparator then orders signed values correctly.
  always_comb begin
    cmp_a_d = '0;
    cmp_b_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (arb_idx == IDX_W'(k)) begin
        cmp_a_d = op_a[16*k +: 16];
        cmp_b_d = op_b[16*k +: 16];
      end
    end
    if (sgn[arb_idx]) begin
      cmp_a_d[15] = ~cmp_a_d[15];
      cmp_b_d[15] = ~cmp_b_d[15];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      srv_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      res_gt_q <= 1'b0;
      res_lt_q <= 1'b0;
      res_eq_q <= 1'b0;
      busy_q   <= 1'b0;
      cmp_a_q  <= '0;
      cmp_b_q  <= '0;
    end else begin
      done_q <= '0;

      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q <= ST_WAIT;
            busy_q  <= 1'b1;
          end
        end

        ST_WAIT: begin
          // Comparator outputs are only trusted on this edge; the ripple
          // path has had SETTLE cycles since the operands were registered.
          if (cnt_q == '0) begin
            res_gt_q <= cmp_gt;
            res_lt_q <= cmp_lt;
            res_eq_q <= cmp_eq;
            done_q   <= gnt_q;
            gnt_q    <= '0;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_DONE: begin
          if (arb_valid) begin
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          gnt_q   <= '0;
        end
      endcase

      // Issue-edge actions shared by IDLE and DONE.
      if (issue) begin
        gnt_q   <= NUM_REQ'(1) << arb_idx;
        srv_q   <= arb_idx;
        ptr_q   <= ptr_d;
        cnt_q   <= CNT_W'(SETTLE - 1);
        cmp_a_q <= cmp_a_d;
        cmp_b_q <= cmp_b_d;
      end
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign res_gt = res_gt_q;
  assign res_lt = res_lt_q;
  assign res_eq = res_eq_q;
  assign busy   = busy_q;
  assign cmp_a  = cmp_a_q;
  assign cmp_b  = cmp_b_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// tb/tb_cmp_arbiter.sv - scoreboard bench for cmp_arbiter with a behavioural comparator

module tb_cmp_arbiter;

  localparam int N = 4;
  localparam int S = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    sgn;
  logic [16*N-1:0] op_a;
  logic [16*N-1:0] op_b;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            res_gt, res_lt, res_eq, busy;
  logic [15:0]     cmp_a, cmp_b;
  logic            cmp_gt_in, cmp_lt_in, cmp_eq_in;
  logic            cmp_gt, cmp_lt, cmp_eq;

  always #5 clk = ~clk;

  // Shared comparator, unsigned magnitude with the cascade folded in.
  assign cmp_gt = (cmp_a > cmp_b) || ((cmp_a == cmp_b) && cmp_gt_in);
  assign cmp_lt = (cmp_a < cmp_b) || ((cmp_a == cmp_b) && cmp_lt_in);
  assign cmp_eq = (cmp_a == cmp_b) && cmp_eq_in;

  cmp_arbiter #(.NUM_REQ(N), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .sgn(sgn), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .done(done), .res_gt(res_gt), .res_lt(res_lt), .res_eq(res_eq),
    .busy(busy), .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_gt_in(cmp_gt_in),
    .cmp_lt_in(cmp_lt_in), .cmp_eq_in(cmp_eq_in), .cmp_gt(cmp_gt),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq)
  );

  typedef struct {
    int          idx;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        gt;
    logic        lt;
    logic        eq;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          model_ptr = 0;
  logic [15:0] ta [N];
  logic [15:0] tbv[N];
  logic [N-1:0] ts;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse; checks grant/operands while serving.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=%b expected no done", done);
        end else begin
          me = sb.pop_front();
          chk("done_onehot", 32'(done), 32'(1) << me.idx);
          chk("res_gt", 32'(res_gt), 32'(me.gt));
          chk("res_lt", 32'(res_lt), 32'(me.lt));
          chk("res_eq", 32'(res_eq), 32'(me.eq));
          chk("done_cycle", 32'(cyc), 32'(me.due));
          chk("gnt_clear_in_done", 32'(gnt), 32'd0);
        end
      end else if (busy && sb.size() != 0) begin
        chk("gnt_onehot", 32'(gnt), 32'(1) << sb[0].idx);
        chk("cmp_a", 32'(cmp_a), 32'(sb[0].ea));
        chk("cmp_b", 32'(cmp_b), 32'(sb[0].eb));
      end
    end
  end

  // Raise the requesters in mask together and predict the full service order.
  // Each requester drops req in the cycle after its done; those in early drop
  // req in the cycle after their grant.
  task automatic phase(input logic [N-1:0] mask, input logic [N-1:0] early);
    logic [N-1:0] pend;
    logic [N-1:0] done_prev;
    logic [15:0]  a, b;
    exp_t         e;
    int           k, i, budget;
    logic         found;
    budget = 0;
    while (busy && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    op_a = {ta[3], ta[2], ta[1], ta[0]};
    op_b = {tbv[3], tbv[2], tbv[1], tbv[0]};
    sgn  = ts;
    pend = mask;
    k    = 0;
    while (pend != '0) begin
      found = 1'b0;
      i = 0;
      for (int s = 0; s < N; s++) begin
        if (!found && pend[(model_ptr + s) % N]) begin
          found = 1'b1;
          i = (model_ptr + s) % N;
        end
      end
      a = ta[i];
      b = tbv[i];
      e.idx = i;
      if (ts[i]) begin
        e.gt = $signed(a) > $signed(b);
        e.lt = $signed(a) < $signed(b);
      end else begin
        e.gt = a > b;
        e.lt = a < b;
      end
      e.eq  = (a == b);
      e.ea  = ts[i] ? (a ^ 16'h8000) : a;
      e.eb  = ts[i] ? (b ^ 16'h8000) : b;
      e.due = cyc + 1 + S + k * (S + 1);
      sb.push_back(e);
      pend[i]   = 1'b0;
      model_ptr = (i + 1) % N;
      k++;
    end
    req       = mask;
    done_prev = '0;
    budget    = 0;
    while ((sb.size() != 0 || busy || req != '0) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (done_prev != '0 && sb.size() == 0) begin
        chk("busy_after_last_done", 32'(busy), 32'd0);
      end
      req       = req & ~done_prev & ~(gnt & early);
      done_prev = done;
    end
    if (budget >= 200) begin
      checks++;
      errors++;
      $display("FAIL phase_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
      req = '0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    sgn   = '0;
    op_a  = '0;
    op_b  = '0;
    for (int r = 0; r < N; r++) begin
      ta[r]  = '0;
      tbv[r] = '0;
    end
    ts = '0;

    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", {29'd0, res_gt, res_lt, res_eq}, 32'd0);
    chk("rst_cmp_a", 32'(cmp_a), 32'd0);
    chk("rst_cmp_b", 32'(cmp_b), 32'd0);
    chk("cascade", {29'd0, cmp_gt_in, cmp_lt_in, cmp_eq_in}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned 0x8000 vs 0x7FFF on requester 0.
    ta[0] = 16'h8000; tbv[0] = 16'h7FFF; ts = 4'b0000;
    phase(4'b0001, 4'b0000);
    // Same operands on requester 1, signed.
    ta[1] = 16'h8000; tbv[1] = 16'h7FFF; ts = 4'b0010;
    phase(4'b0010, 4'b0000);
    // Equal operands on requester 2.
    ta[2] = 16'h1234; tbv[2] = 16'h1234; ts = 4'b0000;
    phase(4'b0100, 4'b0000);
    // Requester 3 drops req right after its grant.
    ta[3] = 16'h0005; tbv[3] = 16'h0009;
    phase(4'b1000, 4'b1000);
    // Everyone at once, then a sparse pattern.
    for (int r = 0; r < N; r++) begin
      ta[r]  = 16'(r * 16'h1111);
      tbv[r] = 16'h2222;
    end
    ts = 4'b0101;
    phase(4'b1111, 4'b0000);
    phase(4'b0101, 4'b0000);
    ta[3] = 16'h0005; tbv[3] = 16'h0009; ts = 4'b0000;
    phase(4'b1000, 4'b0000);

    // Reset in the middle of WAIT: requester 0 is granted, pointer moves to 1.
    @(negedge clk);
    ta[0] = 16'h00F0; tbv[0] = 16'h0F00;
    op_a  = {ta[3], ta[2], ta[1], ta[0]};
    op_b  = {tbv[3], tbv[2], tbv[1], tbv[0]};
    req   = 4'b0001;
    @(negedge clk);
    chk("pre_reset_gnt", 32'(gnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_res", {29'd0, res_gt, res_lt, res_eq}, 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(done), 32'd0);
    end
    rst_n     = 1'b1;
    model_ptr = 0;
    phase(4'b0011, 4'b0000);

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < N; r++) begin
        ta[r]  = 16'($urandom);
        tbv[r] = ($urandom_range(0, 3) == 0) ? ta[r] : 16'($urandom);
      end
      ts = 4'($urandom);
      phase(4'($urandom_range(1, 15)), 4'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_arbiter.md
Name: cmp_arbiter

Overview:
- Round-robin scheduler that shares one 16-bit ripple magnitude comparator (MSB-first cascade, cascade inputs gt_in/lt_in/eq_in) among NUM_REQ requesters.
- Registers the granted requester's operands onto the comparator inputs and waits SETTLE cycles for the ripple path to settle (multicycle path).
- Captures gt/lt/eq, then returns them to the requester with a one-cycle done pulse.
- Sits between the expression-evaluation units and the shared comparator instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SETTLE, 2, cycles the comparator inputs are held before the result is sampled (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- sgn  in  NUM_REQ  per-requester signed-compare select (1 = two's complement).
- op_a  in  16*NUM_REQ  operand A, requester i at bits [16i+15:16i].
- op_b  in  16*NUM_REQ  operand B, same packing as op_a.
- gnt  out  NUM_REQ  one-hot grant; high while requester is being served.
- done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- res_gt  out  1  registered A>B.
- res_lt  out  1  registered A<B.
- res_eq  out  1  registered A==B.
- busy  out  1  high in any state other than IDLE.
- cmp_a  out  16  registered comparator operand A.
- cmp_b  out  16  registered comparator operand B.
- cmp_gt_in  out  1  cascade input to comparator, constant 0.
- cmp_lt_in  out  1  cascade input to comparator, constant 0.
- cmp_eq_in  out  1  cascade input to comparator, constant 1.
- cmp_gt  in  1  comparator output.
- cmp_lt  in  1  comparator output.
- cmp_eq  in  1  comparator output.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt, done, res_gt, res_lt, busy, cmp_a, cmp_b = 0; res_eq=0.
  - Round-robin pointer = 0. Cascade outputs are constants and unaffected.
- States:
  - IDLE: arbitrate; any req → ISSUE-edge actions, go to WAIT.
  - WAIT: down-counter loaded with SETTLE-1 at grant. At count==0, sample cmp_gt/lt/eq into res_* and go to DONE.
  - DONE: done[i]=1 for the served i, gnt cleared. Arbitrate again; with the just-served requester masked, go straight to WAIT on a grant, else go to IDLE.
- Arbitration:
  - Search starts at pointer, wraps modulo NUM_REQ; the first set req wins.
  - On a grant to i, pointer becomes (i+1) mod NUM_REQ.
- Operand registration (issue edge):
  - cmp_a = op_a[i] and cmp_b = op_b[i], each with bit 15 inverted when sgn[i]=1. This makes signed order equal unsigned order.
  - gnt[i]=1 from the issue edge until the DONE cycle.
- Latency:
  - req sampled at edge E0 → done high in the cycle after edge E(SETTLE).
  - Back-to-back service: next grant issued at edge E(SETTLE+1), so one request every SETTLE+1 cycles.
- Result timing: res_* are valid from the DONE cycle and hold until the next capture.
- Requester protocol:
  - Operands and sgn must be stable from the issue edge through the DONE cycle. cmp_a/cmp_b are registered, so only the issue-edge value matters.
  - req must drop in the cycle after done, otherwise it is a new request.
- Boundary conditions:
  - req deasserted mid-operation: the operation completes and done still pulses.
  - Reset mid-WAIT: everything clears immediately; no done pulse for the aborted op.
  - All requesters asserting: strict rotation; each is served once per NUM_REQ grants.
  - SETTLE=1: capture on the first WAIT edge.
  - cmp_* inputs are ignored outside the capture edge.

Test Plan:
- Req0 unsigned, A=0x8000, B=0x7FFF, SETTLE=2: gnt=0001 after E0; done=0001 after E2; res_gt=1, res_lt=0, res_eq=0.
- Req1 signed, same operands: cmp_a=0x0000, cmp_b=0xFFFF; res_lt=1 (−32768 < 32767).
- Req2 A=B=0x1234: res_eq=1, res_gt=0, res_lt=0.
- req=1111 held, each requester dropping req after its done: grants 0,1,2,3 in order with done spaced 3 cycles apart. Then req=0101 with pointer at 0: grant 0 then 2.
- rst_n low during WAIT: gnt, busy, res_* = 0 asynchronously; no done pulse. After release, a pending req is granted with the pointer restarted at 0.
- Req3 dropped one cycle after grant: done[3] still pulses after E2 with a valid result; busy falls the following cycle.
